// File: rtl/rep_seq_pkg.sv
// ---------------------------------------------------------------------------
// rep_seq_pkg
//   Shared definitions for the REP string-instruction sequencer:
//   rep_mode encodings, sequencer state encoding and the operand-size to
//   pointer-step table.
// ---------------------------------------------------------------------------
package rep_seq_pkg;

    // Pointer step values never exceed 8 bytes, so 4 bits hold any step.
    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        REP_NONE  = 2'b00,
        REP_REP   = 2'b01,
        REP_REPE  = 2'b10,
        REP_REPNE = 2'b11
    } rep_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_WAIT_ZF = 2'b10,
        ST_DONE    = 2'b11
    } seq_state_e;

    // Operand size code to byte step: 00=1, 01=2, 10=4, 11=8.
    function automatic logic [STEP_W-1:0] opsize_step(input logic [1:0] opsize);
        logic [STEP_W-1:0] step;
        case (opsize)
            2'b00:   step = 4'd1;
            2'b01:   step = 4'd2;
            2'b10:   step = 4'd4;
            default: step = 4'd8;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/rep_sequencer_ptr_step.sv
// ---------------------------------------------------------------------------
// rep_ptr_step
//   Combinational pointer stepper. Adds or subtracts a byte step from a
//   pointer. In 16-bit addressing only bits [15:0] change (wrapping at
//   64 KiB) and the upper bits pass through; otherwise the full pointer
//   wraps modulo 2^ADDR_W.
// Ports
//   ptr_in   in  ADDR_W  current pointer
//   step     in  STEP_W  byte step (1/2/4/8)
//   dec      in  1       1 = subtract, 0 = add
//   addr16   in  1       16-bit wrap mode
//   ptr_out  out ADDR_W  stepped pointer
// ---------------------------------------------------------------------------
module rep_ptr_step
    import rep_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] ptr_in,
    input  logic [STEP_W-1:0] step,
    input  logic              dec,
    input  logic              addr16,
    output logic [ADDR_W-1:0] ptr_out
);

    logic [ADDR_W-1:0] step_ext;
    logic [ADDR_W-1:0] full_next;
    logic [15:0]       low_next;
    logic [15:0]       step16;

    assign step_ext  = {{(ADDR_W-STEP_W){1'b0}}, step};
    assign step16    = {{(16-STEP_W){1'b0}}, step};
    assign full_next = dec ? (ptr_in - step_ext) : (ptr_in + step_ext);
    assign low_next  = dec ? (ptr_in[15:0] - step16) : (ptr_in[15:0] + step16);

    always_comb begin
        if (addr16) begin
            ptr_out        = ptr_in;
            ptr_out[15:0]  = low_next;
        end else begin
            ptr_out = full_next;
        end
    end

endmodule

// File: rtl/rep_sequencer.sv
// ---------------------------------------------------------------------------
// rep_sequencer
//   Sequences REP / REPE / REPNE string instructions through the
//   register-read / address-gen stage. Latches count, SI/DI, operand size,
//   direction and addressing mode for one string op, issues one iteration per
//   downstream handshake while stepping the pointers, holds the front end
//   stalled until the loop ends by count or ZF, then strobes a writeback of
//   the remaining count and final pointers.
//
// Build option
//   REP_SEQ_INTR_EN : adds input intr_pending; a pending interrupt seen in
//                     ISSUE (without acceptance) or WAIT_ZF (without a
//                     matching ZF) ends the loop early with a writeback of
//                     the current state so the instruction can restart.
//
// Ports
//   clk, clr                    clock, asynchronous active-high reset
//   start_valid, rep_mode       string op present / REP prefix type
//   count_in, si_in, di_in      initial ECX / ESI / EDI
//   opsize, df, addr16          operand size, direction, 16-bit addressing
//   down_ready                  downstream accepts the current iteration
//   zf_valid, zf_tag, zf        ZF result returned from execute
//   flush                       synchronous pipeline flush
//   intr_pending                (REP_SEQ_INTR_EN only) interrupt request
//   busy_stall                  upstream hold, high whenever not IDLE
//   iter_valid/kill/last/tag    iteration handshake and attributes
//   iter_si, iter_di            pointers for the current iteration
//   wb_valid, wb_count          final writeback strobe and remaining count
//   wb_si, wb_di                final pointers
// ---------------------------------------------------------------------------
module rep_sequencer
    import rep_seq_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 7
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start_valid,
    input  logic [1:0]        rep_mode,
    input  logic [CNT_W-1:0]  count_in,
    input  logic [ADDR_W-1:0] si_in,
    input  logic [ADDR_W-1:0] di_in,
    input  logic [1:0]        opsize,
    input  logic              df,
    input  logic              addr16,
    input  logic              down_ready,
    input  logic              zf_valid,
    input  logic [ID_W-1:0]   zf_tag,
    input  logic              zf,
    input  logic              flush,
`ifdef REP_SEQ_INTR_EN
    input  logic              intr_pending,
`endif
    output logic              busy_stall,
    output logic              iter_valid,
    output logic              iter_kill,
    output logic              iter_last,
    output logic [ID_W-1:0]   iter_tag,
    output logic [ADDR_W-1:0] iter_si,
    output logic [ADDR_W-1:0] iter_di,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  wb_count,
    output logic [ADDR_W-1:0] wb_si,
    output logic [ADDR_W-1:0] wb_di
);

    seq_state_e        state_q, state_d;
    rep_mode_e         mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] si_q, si_d;
    logic [ADDR_W-1:0] di_q, di_d;
    logic [1:0]        opsize_q, opsize_d;
    logic              df_q, df_d;
    logic              a16_q, a16_d;
    // Set when the op started with a zero count: DONE first presents a
    // single killed iteration before the writeback strobe.
    logic              kill_q, kill_d;
    logic [ID_W-1:0]   tag_q, tag_d;
    logic [ID_W-1:0]   last_tag_q, last_tag_d;

    logic [CNT_W-1:0]  cnt_eff;
    logic [CNT_W-1:0]  cnt_dec;
    logic [ADDR_W-1:0] si_step;
    logic [ADDR_W-1:0] di_step;
    logic [STEP_W-1:0] step_bytes;
    logic              start_zero;
    logic              cnt_is_one;
    logic              zf_hit;
    logic              zf_exit;
    logic              intr_req;

`ifdef REP_SEQ_INTR_EN
    assign intr_req = intr_pending;
`else
    assign intr_req = 1'b0;
`endif

    assign step_bytes = opsize_step(opsize_q);

    rep_ptr_step #(.ADDR_W(ADDR_W)) u_si_step (
        .ptr_in  (si_q),
        .step    (step_bytes),
        .dec     (df_q),
        .addr16  (a16_q),
        .ptr_out (si_step)
    );

    rep_ptr_step #(.ADDR_W(ADDR_W)) u_di_step (
        .ptr_in  (di_q),
        .step    (step_bytes),
        .dec     (df_q),
        .addr16  (a16_q),
        .ptr_out (di_step)
    );

    // In 16-bit mode only CX counts; the upper count bits ride along unchanged.
    always_comb begin
        cnt_eff = '0;
        cnt_dec = cnt_q;
        if (a16_q) begin
            cnt_eff[15:0] = cnt_q[15:0];
            cnt_dec[15:0] = cnt_q[15:0] - 16'd1;
        end else begin
            cnt_eff = cnt_q;
            cnt_dec = cnt_q - CNT_W'(1);
        end
    end

    assign start_zero = addr16 ? (count_in[15:0] == 16'd0) : (count_in == '0);
    assign cnt_is_one = (cnt_eff == CNT_W'(1));
    // Only the ZF of the most recently issued iteration may end the loop.
    assign zf_hit     = zf_valid && (zf_tag == last_tag_q);
    assign zf_exit    = ((mode_q == REP_REPE) && !zf) || ((mode_q == REP_REPNE) && zf);

    // Outputs decode from registered state so a reset clears them at once.
    always_comb begin
        busy_stall = (state_q != ST_IDLE);
        iter_valid = 1'b0;
        iter_kill  = 1'b0;
        iter_last  = 1'b0;
        iter_tag   = '0;
        iter_si    = '0;
        iter_di    = '0;
        wb_valid   = 1'b0;
        wb_count   = '0;
        wb_si      = '0;
        wb_di      = '0;
        case (state_q)
            ST_ISSUE: begin
                iter_valid = 1'b1;
                iter_last  = cnt_is_one;
                iter_tag   = tag_q;
                iter_si    = si_q;
                iter_di    = di_q;
            end
            ST_DONE: begin
                if (kill_q) begin
                    iter_valid = 1'b1;
                    iter_kill  = 1'b1;
                    iter_last  = 1'b1;
                    iter_tag   = tag_q;
                    iter_si    = si_q;
                    iter_di    = di_q;
                end else if (!flush) begin
                    // A flush in the writeback cycle suppresses the strobe.
                    wb_valid = 1'b1;
                    wb_count = cnt_q;
                    wb_si    = si_q;
                    wb_di    = di_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        si_d       = si_q;
        di_d       = di_q;
        opsize_d   = opsize_q;
        df_d       = df_q;
        a16_d      = a16_q;
        kill_d     = kill_q;
        tag_d      = tag_q;
        last_tag_d = last_tag_q;

        if (flush) begin
            state_d = ST_IDLE;
            kill_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid && (rep_mode != REP_NONE)) begin
                        mode_d   = rep_mode_e'(rep_mode);
                        cnt_d    = count_in;
                        si_d     = si_in;
                        di_d     = di_in;
                        opsize_d = opsize;
                        df_d     = df;
                        a16_d    = addr16;
                        kill_d   = start_zero;
                        state_d  = start_zero ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (down_ready) begin
                        if (cnt_eff != '0) begin
                            cnt_d = cnt_dec;
                        end
                        si_d       = si_step;
                        di_d       = di_step;
                        tag_d      = tag_q + ID_W'(1);
                        last_tag_d = tag_q;
                        if (cnt_eff <= CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end else if (mode_q == REP_REP) begin
                            state_d = ST_ISSUE;
                        end else begin
                            state_d = ST_WAIT_ZF;
                        end
                    end else if (intr_req) begin
                        state_d = ST_DONE;
                    end
                end
                ST_WAIT_ZF: begin
                    if (zf_hit) begin
                        state_d = zf_exit ? ST_DONE : ST_ISSUE;
                    end else if (intr_req) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (kill_q) begin
                        if (down_ready) begin
                            kill_d     = 1'b0;
                            tag_d      = tag_q + ID_W'(1);
                            last_tag_d = tag_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            mode_q     <= REP_NONE;
            cnt_q      <= '0;
            si_q       <= '0;
            di_q       <= '0;
            opsize_q   <= 2'b00;
            df_q       <= 1'b0;
            a16_q      <= 1'b0;
            kill_q     <= 1'b0;
            tag_q      <= '0;
            last_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            si_q       <= si_d;
            di_q       <= di_d;
            opsize_q   <= opsize_d;
            df_q       <= df_d;
            a16_q      <= a16_d;
            kill_q     <= kill_d;
            tag_q      <= tag_d;
            last_tag_q <= last_tag_d;
        end
    end

endmodule

// File: tb/tb_rep_sequencer.sv
module tb_rep_sequencer;
    import rep_seq_pkg::*;

    logic        clk;
    logic        clr;
    logic        start_valid;
    logic [1:0]  rep_mode;
    logic [31:0] count_in;
    logic [31:0] si_in;
    logic [31:0] di_in;
    logic [1:0]  opsize;
    logic        df;
    logic        addr16;
    logic        down_ready;
    logic        zf_valid;
    logic [6:0]  zf_tag;
    logic        zf;
    logic        flush;
`ifdef REP_SEQ_INTR_EN
    logic        intr_pending;
`endif
    logic        busy_stall;
    logic        iter_valid;
    logic        iter_kill;
    logic        iter_last;
    logic [6:0]  iter_tag;
    logic [31:0] iter_si;
    logic [31:0] iter_di;
    logic        wb_valid;
    logic [31:0] wb_count;
    logic [31:0] wb_si;
    logic [31:0] wb_di;

    rep_sequencer #(.CNT_W(32), .ADDR_W(32), .ID_W(7)) dut (
        .clk         (clk),
        .clr         (clr),
        .start_valid (start_valid),
        .rep_mode    (rep_mode),
        .count_in    (count_in),
        .si_in       (si_in),
        .di_in       (di_in),
        .opsize      (opsize),
        .df          (df),
        .addr16      (addr16),
        .down_ready  (down_ready),
        .zf_valid    (zf_valid),
        .zf_tag      (zf_tag),
        .zf          (zf),
        .flush       (flush),
`ifdef REP_SEQ_INTR_EN
        .intr_pending(intr_pending),
`endif
        .busy_stall  (busy_stall),
        .iter_valid  (iter_valid),
        .iter_kill   (iter_kill),
        .iter_last   (iter_last),
        .iter_tag    (iter_tag),
        .iter_si     (iter_si),
        .iter_di     (iter_di),
        .wb_valid    (wb_valid),
        .wb_count    (wb_count),
        .wb_si       (wb_si),
        .wb_di       (wb_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] count;
        logic [31:0] si;
        logic [31:0] di;
        logic [1:0]  opsize;
        logic        df;
        logic        a16;
        logic [7:0]  zf_seq;   // bit k = ZF returned after iteration k
        logic        stale;    // send one wrong-tag ZF before the first real one
        int          stall;    // down_ready low for this many ISSUE cycles
        int          iters;
        logic [31:0] wb_cnt;
        logic [31:0] wb_si;
        logic [31:0] wb_di;
        string       name;
    } vec_t;

    typedef struct {
        bit          is_wb;
        logic        kill;
        logic        last;
        logic [31:0] cnt;
        logic [31:0] si;
        logic [31:0] di;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    int          n_cmp;
    int          n_err;
    logic [6:0]  exp_tag_m;
    logic [6:0]  last_tag_m;
    bit          acc_flag;
    bit          acc_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] p, input logic [1:0] osz,
                                               input logic dec, input logic a16);
        logic [31:0] s;
        logic [31:0] r;
        s = 32'd1 << osz;
        r = dec ? (p - s) : (p + s);
        if (a16) r = {p[31:16], r[15:0]};
        return r;
    endfunction

    // Sampled at the falling edge; pops the scoreboard on each handshake.
    task automatic monitor();
        acc_flag = 0;
        acc_last = 0;
        if (iter_valid) begin
            if (sb.size() == 0 || sb[0].is_wb) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_iter: got si=%h tag=%0d, want no iteration", iter_si, iter_tag);
            end else begin
                chk("iter_kill", 32'(iter_kill), 32'(sb[0].kill));
                chk("iter_last", 32'(iter_last), 32'(sb[0].last));
                chk("iter_si", iter_si, sb[0].si);
                chk("iter_di", iter_di, sb[0].di);
                chk("iter_tag", 32'(iter_tag), 32'(exp_tag_m));
                if (down_ready) begin
                    acc_flag   = 1;
                    acc_last   = sb[0].last | sb[0].kill;
                    last_tag_m = exp_tag_m;
                    exp_tag_m  = exp_tag_m + 7'd1;
                    void'(sb.pop_front());
                end
            end
        end
        if (wb_valid) begin
            if (sb.size() == 0 || !sb[0].is_wb) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_wb: got count=%h si=%h, want no writeback", wb_count, wb_si);
            end else begin
                chk("wb_count", wb_count, sb[0].cnt);
                chk("wb_si", wb_si, sb[0].si);
                chk("wb_di", wb_di, sb[0].di);
                $display("wb: count=%h si=%h di=%h", wb_count, wb_si, wb_di);
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t v);
        logic [31:0] ce;
        logic [31:0] s;
        logic [31:0] d;
        exp_t        e;
        int          stall_left;
        int          k;
        int          budget;
        bit          stale_done;
        ce = v.a16 ? {16'h0, v.count[15:0]} : v.count;
        s  = v.si;
        d  = v.di;
        if (ce == 32'd0) begin
            e = '{is_wb: 0, kill: 1'b1, last: 1'b1, cnt: 32'd0, si: s, di: d};
            sb.push_back(e);
        end else begin
            for (int i = 0; i < v.iters; i++) begin
                e = '{is_wb: 0, kill: 1'b0, last: (32'(i) == ce - 32'd1), cnt: 32'd0, si: s, di: d};
                sb.push_back(e);
                s = model_step(s, v.opsize, v.df, v.a16);
                d = model_step(d, v.opsize, v.df, v.a16);
            end
        end
        e = '{is_wb: 1, kill: 1'b0, last: 1'b0, cnt: v.wb_cnt, si: v.wb_si, di: v.wb_di};
        sb.push_back(e);

        start_valid = 1'b1;
        rep_mode    = v.mode;
        count_in    = v.count;
        si_in       = v.si;
        di_in       = v.di;
        opsize      = v.opsize;
        df          = v.df;
        addr16      = v.a16;
        down_ready  = (v.stall == 0);
        tick();
        start_valid = 1'b0;

        stall_left = v.stall;
        k          = 0;
        stale_done = 0;
        budget     = 200;
        while (sb.size() > 0 && budget > 0) begin
            if (stall_left > 0) begin
                down_ready = 1'b0;
                stall_left--;
            end else begin
                down_ready = 1'b1;
            end
            tick();
            zf_valid = 1'b0;
            if (acc_flag && !acc_last && (v.mode == REP_REPE || v.mode == REP_REPNE)) begin
                if (v.stale && !stale_done) begin
                    // Wrong tag with a ZF value that would end the loop if taken.
                    zf_valid   = 1'b1;
                    zf_tag     = last_tag_m + 7'd1;
                    zf         = (v.mode == REP_REPNE);
                    tick();
                    stale_done = 1;
                end
                zf_valid = 1'b1;
                zf_tag   = last_tag_m;
                zf       = v.zf_seq[k];
                k++;
            end
            budget--;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%s: got %0d pending, want 0", v.name, sb.size());
            sb.delete();
        end
        zf_valid   = 1'b0;
        down_ready = 1'b1;
        tick();
        chk({"idle_after_", v.name}, 32'(busy_stall), 32'd0);
        $display("row %s: iterations=%0d done", v.name, v.iters);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        exp_tag_m   = 7'd0;
        last_tag_m  = 7'd0;
        acc_flag    = 0;
        acc_last    = 0;
        clr         = 1'b1;
        start_valid = 1'b0;
        rep_mode    = 2'b00;
        count_in    = 32'd0;
        si_in       = 32'd0;
        di_in       = 32'd0;
        opsize      = 2'b00;
        df          = 1'b0;
        addr16      = 1'b0;
        down_ready  = 1'b1;
        zf_valid    = 1'b0;
        zf_tag      = 7'd0;
        zf          = 1'b0;
        flush       = 1'b0;
`ifdef REP_SEQ_INTR_EN
        intr_pending = 1'b0;
`endif

        vecs[0] = '{2'b01, 32'd3, 32'h100, 32'h200, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 0, 3,
                    32'd0, 32'h10C, 32'h20C, "rep3"};
        vecs[1] = '{2'b01, 32'd0, 32'h300, 32'h400, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1,
                    32'd0, 32'h300, 32'h400, "cnt0"};
        vecs[2] = '{2'b10, 32'd5, 32'h1000, 32'h2000, 2'b00, 1'b0, 1'b0, 8'b011, 1'b1, 0, 3,
                    32'd2, 32'h1003, 32'h2003, "repe"};
        vecs[3] = '{2'b01, 32'd2, 32'h50, 32'h60, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 4, 2,
                    32'd0, 32'h4C, 32'h5C, "stall"};
        vecs[4] = '{2'b01, 32'h0001_0001, 32'h0001_FFFF, 32'h0002_FFFE, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 0, 1,
                    32'h0001_0000, 32'h0001_0000, 32'h0002_FFFF, "a16wrap"};
        vecs[5] = '{2'b11, 32'd4, 32'h20, 32'h40, 2'b11, 1'b1, 1'b0, 8'b10, 1'b0, 0, 2,
                    32'd2, 32'h10, 32'h30, "repne"};
        vecs[6] = '{2'b01, 32'h0005_0000, 32'h1234, 32'h5678, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0, 0, 1,
                    32'h0005_0000, 32'h1234, 32'h5678, "a16cnt0"};
        vecs[7] = '{2'b01, 32'd1, 32'h2, 32'h0, 2'b10, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1,
                    32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFC, "wrap32"};
        vecs[8] = '{2'b01, 32'd1, 32'hABCD_0000, 32'h0, 2'b01, 1'b1, 1'b1, 8'h00, 1'b0, 0, 1,
                    32'd0, 32'hABCD_FFFE, 32'h0000_FFFE, "a16dec"};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_stall), 32'd0);
        chk("rst_iter_valid", 32'(iter_valid), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_iter_tag", 32'(iter_tag), 32'd0);
        clr = 1'b0;
        tick();

        for (int r = 0; r < 9; r++) begin
            run_row(vecs[r]);
        end

        // Flush in WAIT_ZF with a matching, loop-ending ZF in the same cycle.
        sb.push_back('{is_wb: 0, kill: 1'b0, last: 1'b0, cnt: 32'd0, si: 32'h500, di: 32'h600});
        start_valid = 1'b1;
        rep_mode    = 2'b10;
        count_in    = 32'd5;
        si_in       = 32'h500;
        di_in       = 32'h600;
        opsize      = 2'b00;
        df          = 1'b0;
        addr16      = 1'b0;
        down_ready  = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        chk("flush_first_accept", 32'(acc_flag), 32'd1);
        flush    = 1'b1;
        zf_valid = 1'b1;
        zf_tag   = last_tag_m;
        zf       = 1'b0;
        tick();
        flush    = 1'b0;
        zf_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_busy", 32'(busy_stall), 32'd0);
            chk("flush_no_wb", 32'(wb_valid), 32'd0);
        end
        chk("flush_sb_empty", 32'(sb.size()), 32'd0);
        $display("seq flush: done");

        // Asynchronous clear while an iteration is held in ISSUE.
        sb.push_back('{is_wb: 0, kill: 1'b0, last: 1'b0, cnt: 32'd0, si: 32'h700, di: 32'h800});
        start_valid = 1'b1;
        rep_mode    = 2'b01;
        count_in    = 32'd3;
        si_in       = 32'h700;
        di_in       = 32'h800;
        opsize      = 2'b10;
        down_ready  = 1'b0;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        #2;
        clr = 1'b1;
        #1;
        chk("clr_iter_valid", 32'(iter_valid), 32'd0);
        chk("clr_busy", 32'(busy_stall), 32'd0);
        chk("clr_iter_si", iter_si, 32'd0);
        chk("clr_iter_tag", 32'(iter_tag), 32'd0);
        chk("clr_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        clr        = 1'b0;
        sb.delete();
        exp_tag_m  = 7'd0;
        last_tag_m = 7'd0;
        down_ready = 1'b1;
        tick();
        $display("seq clr: done");

        // Tag counter restarts from zero after the clear.
        run_row(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
